writeback_arbiter: RTL
======================

// Module: writeback_arbiter
// PURPOSE
//  Shares the two register-file write ports among all execution-unit result sources.
//  Sources are alu1, alu2, advint rd, advint rd2, memunit and branch (link).
//  Grants up to two results per cycle using rotating round-robin priority.
//  Drives the regfile write ports and the reg1_finished/reg2_finished busy-clear feedback to the scheduler.
// PARAMETERS
//  N_REQ   6   number of result sources; index 0..5 = alu1, alu2, advint_rd, advint_rd2, memunit, branch
//  DATA_W  64  result data width
// PORTS
//  clk            in   1             system clock
//  rst            in   1             reset: one clock; reset is synchronous and active-high
//  req_valid      in   N_REQ         source i holds a completed result
//  req_rn         in   6*N_REQ       destination register of source i, slice [6*i+:6]
//  req_data       in   DATA_W*N_REQ  result of source i, slice [DATA_W*i+:DATA_W]
//  req_ack        out  N_REQ         combinational; result i accepted this cycle
//  wr1_en,wr2_en  out  1             regfile write-port enables (registered)
//  wr1_rn,wr2_rn  out  6             regfile write-port register numbers (registered)
//  wr1_data,wr2_data out DATA_W      regfile write-port data (registered)
//  reg1_finished  out  6             reg written via port 1 this cycle; 0 = none
//  reg2_finished  out  6             reg written via port 2 this cycle; 0 = none
// BEHAVIOUR
//  - Handshake: a source raises req_valid with rn/data stable.
//    It holds them unchanged until the cycle req_ack[i]=1, and may drop valid the next cycle.
//  - Grant: scan sources starting at the priority pointer ptr, wrapping modulo N_REQ.
//    The first valid source gets port 1; the second valid source gets port 2.
//  - The write for a grant in cycle N appears on wr*/reg*_finished in cycle N+1 (1-cycle latency).
//  - R0 rule: a valid source with rn==0 is acked immediately and consumes no port or write.
//    It does not count toward the two grants and does not move ptr.
//  - Same-rn conflict: if the second candidate's rn equals port 1's rn, defer it.
//    Port 2 then takes the next non-conflicting candidate, or stays idle.
//  - ptr update: when at least one port is granted, ptr <= (index of last port grant + 1) mod N_REQ.
//    With no port grants, ptr holds.
//  - Fairness: a continuously valid source with rn!=0 is acked within ceil(N_REQ/2)=3 cycles.
//  - reg1_finished equals wr1_rn when wr1_en=1, otherwise 0; reg2_finished likewise.
//  - req_ack is forced to 0 while rst=1.
//  - Reset, including mid-operation, sets:
//    - wr1_en=wr2_en=0;
//    - wr*_rn=0, wr*_data=0;
//    - reg*_finished=0;
//    - ptr=0.
//  - In-flight unacked requests are re-arbitrated after reset release; nothing is dropped silently.
//  - Single active source: it always takes port 1, and port 2 is idle.
//  - Both ports are never assigned the same source, and never the same nonzero rn, in one cycle.
// TESTING
//  - Single source: alu1 valid, rn=5, data=0xAA, ptr=0 -> ack[0] in cycle 0.
//    Cycle 1 shows wr1_en=1, wr1_rn=5, wr1_data=0xAA, reg1_finished=5, wr2_en=0.
//  - All six valid, rn=1..6, held until acked.
//    -> Cycle grants are {0,1}, {2,3}, {4,5}; every source is acked by cycle 2.
//    -> ptr sequence is 0, 2, 4, 0.
//  - Conflict: alu1 rn=9, alu2 rn=9, memunit rn=12, ptr=0.
//    -> Cycle 0 acks sources 0 and 4. Cycle 1 acks source 1; wr1_rn=9 then 9 on consecutive cycles.
//  - R0: branch rn=0, alu2 rn=3.
//    -> Both acked in the same cycle; only wr1 (rn=3) is written, and reg2_finished=0.
//  - Reset mid-stream: assert rst while 4 sources are pending.
//    -> Next cycle all outputs are 0 and ptr=0.
//    -> After release, pending sources are acked in index order 0..3 over 2 cycles.
//  - Starvation: sources 0 and 1 valid every cycle, source 5 valid, ptr=2.
//    -> Source 5 is acked within 3 cycles.

Source files
------------

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the two register-file write ports among the
// execution-unit result sources (alu1, alu2, advint rd, advint rd2, memunit,
// branch link) using a rotating round-robin pointer.
//
// Handshake: a source raises req_valid[i] with req_rn/req_data stable and
// holds them until the cycle req_ack[i]=1; req_ack is combinational and the
// accepted write appears on the wr*/reg*_finished outputs one cycle later.
module writeback_arbiter #(
   parameter int N_REQ  = 6,
   parameter int DATA_W = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [6*N_REQ-1:0]      req_rn,
   input  logic [DATA_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]        req_ack,
   output logic                    wr1_en,
   output logic                    wr2_en,
   output logic [5:0]              wr1_rn,
   output logic [5:0]              wr2_rn,
   output logic [DATA_W-1:0]       wr1_data,
   output logic [DATA_W-1:0]       wr2_data,
   output logic [5:0]              reg1_finished,
   output logic [5:0]              reg2_finished
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Round-robin pointer and registered write ports.
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              wr1_en_q, wr1_en_d;
   logic              wr2_en_q, wr2_en_d;
   logic [5:0]        wr1_rn_q, wr1_rn_d;
   logic [5:0]        wr2_rn_q, wr2_rn_d;
   logic [DATA_W-1:0] wr1_data_q, wr1_data_d;
   logic [DATA_W-1:0] wr2_data_q, wr2_data_d;

   // Grant scan results.
   logic [N_REQ-1:0]  ack_c;
   logic              p1_hit, p2_hit;
   logic [PTR_W-1:0]  p1_idx, p2_idx;
   logic [5:0]        p1_rn;
   logic [PTR_W-1:0]  scan_idx;
   logic [5:0]        scan_rn;

   // (base + k) mod N_REQ, valid for base < N_REQ and k <= N_REQ.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return PTR_W'(s);
   endfunction

   // Scan from ptr: R0 writes are acked for free, first real result takes
   // port 1, next one whose rn differs from port 1 takes port 2.
   always_comb begin
      ack_c    = '0;
      p1_hit   = 1'b0;
      p2_hit   = 1'b0;
      p1_idx   = '0;
      p2_idx   = '0;
      p1_rn    = '0;
      scan_idx = '0;
      scan_rn  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = wrap_add(ptr_q, k);
         scan_rn  = req_rn[6*scan_idx +: 6];
         if (req_valid[scan_idx]) begin
            if (scan_rn == 6'd0) begin
               ack_c[scan_idx] = 1'b1;
            end else if (!p1_hit) begin
               p1_hit          = 1'b1;
               p1_idx          = scan_idx;
               p1_rn           = scan_rn;
               ack_c[scan_idx] = 1'b1;
            end else if (!p2_hit && (scan_rn != p1_rn)) begin
               p2_hit          = 1'b1;
               p2_idx          = scan_idx;
               ack_c[scan_idx] = 1'b1;
            end
         end
      end
   end

   // Acks are suppressed during reset so held requests re-arbitrate afterwards.
   assign req_ack = rst ? '0 : ack_c;

   // Next write-port contents and pointer advance past the last port grant.
   always_comb begin
      wr1_en_d   = p1_hit;
      wr2_en_d   = p2_hit;
      wr1_rn_d   = p1_hit ? req_rn[6*p1_idx +: 6] : 6'd0;
      wr2_rn_d   = p2_hit ? req_rn[6*p2_idx +: 6] : 6'd0;
      wr1_data_d = p1_hit ? req_data[DATA_W*p1_idx +: DATA_W] : '0;
      wr2_data_d = p2_hit ? req_data[DATA_W*p2_idx +: DATA_W] : '0;
      ptr_d      = ptr_q;
      if (p2_hit)      ptr_d = wrap_add(p2_idx, 1);
      else if (p1_hit) ptr_d = wrap_add(p1_idx, 1);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         wr1_en_q   <= 1'b0;
         wr2_en_q   <= 1'b0;
         wr1_rn_q   <= 6'd0;
         wr2_rn_q   <= 6'd0;
         wr1_data_q <= '0;
         wr2_data_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         wr1_en_q   <= wr1_en_d;
         wr2_en_q   <= wr2_en_d;
         wr1_rn_q   <= wr1_rn_d;
         wr2_rn_q   <= wr2_rn_d;
         wr1_data_q <= wr1_data_d;
         wr2_data_q <= wr2_data_d;
      end
   end

   assign wr1_en        = wr1_en_q;
   assign wr2_en        = wr2_en_q;
   assign wr1_rn        = wr1_rn_q;
   assign wr2_rn        = wr2_rn_q;
   assign wr1_data      = wr1_data_q;
   assign wr2_data      = wr2_data_q;
   assign reg1_finished = wr1_en_q ? wr1_rn_q : 6'd0;
   assign reg2_finished = wr2_en_q ? wr2_rn_q : 6'd0;

endmodule
